// File: rtl/val2_shift_unit.sv
// val2_shift_unit: iterative ARM operand-2 generator with valid/ready handshake and flush.
// Define VAL2_REG_SHIFT_EN to support register-amount shifts (val_Rs).
module val2_shift_unit #(
  parameter int DATA_W = 32,
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] val_Rm,
  input  logic [7:0]        val_Rs,
  input  logic [11:0]       shift_OP,
  input  logic              imm,
  input  logic              read_write,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);
  localparam int RW = $clog2(DATA_W) + 1;
  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROR = 3'd3, RRX = 3'd4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] acc, acc_init, acc_step, ror;
  logic [DATA_W:0] lsl, lsr;
  logic signed [DATA_W:0] asr;
  logic cy, cy_init, cy_step;
  logic [2:0] op, op_init;
  logic [RW-1:0] rem, k;
  logic [8:0] n;
  logic [4:0] amt;
  assign amt = shift_OP[11:7];
`ifdef VAL2_REG_SHIFT_EN
  logic [8:0] lim;
  assign lim = (shift_OP[6:5] == 2'b10) ? 9'(DATA_W) : 9'(DATA_W + 1);
`else
  logic unused_rs;
  assign unused_rs = ^val_Rs;
`endif
  always_comb begin
    acc_init = val_Rm;
    cy_init = carry_in;
    op_init = {1'b0, shift_OP[6:5]};
    n = 9'(amt);
    if (read_write) begin
      acc_init = {{(DATA_W-12){shift_OP[11]}}, shift_OP};
      n = '0;
    end else if (imm) begin
      acc_init = DATA_W'(shift_OP[7:0]);
      op_init = ROR;
      n = 9'({shift_OP[11:8], 1'b0} & 5'(DATA_W - 1));
    end
`ifdef VAL2_REG_SHIFT_EN
    else if (shift_OP[4]) begin
      if (val_Rs == '0) begin
        n = '0;
      end else if (shift_OP[6:5] == 2'b11) begin
        n = 9'(val_Rs & 8'(DATA_W - 1));
        cy_init = (n == '0) ? val_Rm[DATA_W-1] : carry_in;
      end else begin
        n = (9'(val_Rs) > lim) ? lim : 9'(val_Rs);
      end
    end
`endif
    else if (amt == '0 && shift_OP[6:5] != 2'b00) begin
      // LSR/ASR #0 encode a full-width shift; ROR #0 encodes RRX
      op_init = (shift_OP[6:5] == 2'b11) ? RRX : op_init;
      n = (shift_OP[6:5] == 2'b11) ? 9'd1 : 9'(DATA_W);
    end
  end
  assign k = (rem < RW'(STEP)) ? rem : RW'(STEP);
  assign lsl = {cy, acc} << k;
  assign lsr = {acc, cy} >> k;
  assign asr = $signed({acc, cy}) >>> k;
  assign ror = (acc >> k) | (acc << (RW'(DATA_W) - k));
  always_comb begin
    acc_step = op == LSL ? lsl[DATA_W-1:0] : op == LSR ? lsr[DATA_W:1] :
               op == ASR ? asr[DATA_W:1] : op == ROR ? ror : {cy, acc[DATA_W-1:1]};
    cy_step = op == LSL ? lsl[DATA_W] : op == LSR ? lsr[0] :
              op == ASR ? asr[0] : op == ROR ? ror[DATA_W-1] : acc[0];
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (state == IDLE) state_n = in_valid ? ((n == '0) ? DONE : SHIFT) : IDLE;
    else if (state == SHIFT) state_n = (rem <= RW'(STEP)) ? DONE : SHIFT;
    else if (state == DONE) state_n = (out_valid && out_ready) ? IDLE : DONE;
  end
  always_comb in_ready = (state == IDLE);
  // result is registered one cycle after DONE is entered, then held until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cy <= 1'b0;
      op <= '0;
      rem <= '0;
      val2 <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      acc <= acc_init;
      cy <= cy_init;
      op <= op_init;
      rem <= n[RW-1:0];
    end else if (state == SHIFT) begin
      acc <= acc_step;
      cy <= cy_step;
      rem <= rem - k;
    end else if (state == DONE) begin
      out_valid <= !(out_valid && out_ready);
      if (!out_valid) begin
        val2 <= acc;
        carry_out <= cy;
      end
    end
  end
endmodule
